// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: two writeback requesters, hold input and register-file write port
interface rf_write_arbiter_if #(parameter int width = 32);
   logic             req0_valid;
   logic             req0_ready;
   logic [4:0]       req0_addr;
   logic [width-1:0] req0_data;
   logic             req1_valid;
   logic             req1_ready;
   logic [4:0]       req1_addr;
   logic [width-1:0] req1_data;
   logic             rf_hold;
   logic             rf_en;
   logic [4:0]       write_addr;
   logic [width-1:0] write_data;
   logic             init_done;
   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, rf_hold,
      input  req0_ready, req1_ready, rf_en, write_addr, write_data, init_done
   );
   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, rf_hold,
      output req0_ready, req1_ready, rf_en, write_addr, write_data, init_done
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: zero-sweeps x1..x31 after reset, then arbitrates two writeback requesters onto the register-file write port (RF_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority)
module rf_write_arbiter #(
   parameter int width = 32
) (
   input logic clk,
   input logic rst,
   rf_write_arbiter_if.slave bus
);
   typedef enum logic {INIT, RUN} state_t;
   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             last_q;
   logic             gnt0, gnt1, go, acc;
   logic [4:0]       sel_addr;
   logic [width-1:0] sel_data;
   // state register and sweep counter
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= INIT;
         cnt_q   <= 5'd1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // sweep advances on every unheld INIT cycle; issuing x31 hands over to RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT && !bus.rf_hold) begin
         cnt_d   = cnt_q + 5'd1;
         state_d = (cnt_q == 5'd31) ? RUN : INIT;
      end
   end
   // grant selection; last_q=1 means requester 1 was granted last, so requester 0 goes next
   always_comb begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      gnt0 = bus.req0_valid & (!bus.req1_valid | last_q);
      gnt1 = bus.req1_valid & (!bus.req0_valid | !last_q);
`else
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid & !bus.req0_valid;
`endif
      go       = (state_q == RUN) & !bus.rf_hold;
      acc      = go & (gnt0 | gnt1);
      sel_addr = gnt0 ? bus.req0_addr : bus.req1_addr;
      sel_data = gnt0 ? bus.req0_data : bus.req1_data;
   end
   assign bus.req0_ready = go & gnt0;
   assign bus.req1_ready = go & gnt1;
   assign bus.init_done  = (state_q == RUN);
   // registered write port: sweep zeros in INIT, winner's write in RUN; x0 writes are accepted but not strobed
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bus.rf_en      <= 1'b0;
         bus.write_addr <= 5'd0;
         bus.write_data <= '0;
         last_q         <= 1'b1;
      end else if (state_q == INIT) begin
         bus.rf_en <= !bus.rf_hold;
         if (!bus.rf_hold) begin
            bus.write_addr <= cnt_q;
            bus.write_data <= '0;
         end
      end else if (acc) begin
         bus.rf_en      <= (sel_addr != 5'd0);
         bus.write_addr <= sel_addr;
         bus.write_data <= sel_data;
         last_q         <= gnt1;
      end else begin
         bus.rf_en <= 1'b0;
      end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized and directed checks of rf_write_arbiter against a behavioural model and a bench register file
module tb_rf_write_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   rf_write_arbiter_if #(.width(32)) bus ();
   rf_write_arbiter #(.width(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   // bench register file fed only by the DUT write port
   logic [31:0] rf [32] = '{default: 32'ha5a5a5a5};
   always @(posedge clk)
      if (bus.rf_en && bus.write_addr != 5'd0) rf[bus.write_addr] <= bus.write_data;
   // reference model
   bit          m_run;
   int          m_sweep;
   int          m_last;
   bit          e_en;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   logic [31:0] mem [32] = '{default: 32'ha5a5a5a5};
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_run = 0; m_sweep = 1; m_last = 1;
      e_en = 0; e_addr = 0; e_data = 0;
   endtask
   task automatic reset_now();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_rf_en", bus.rf_en, 0);
      chk("rst_addr", bus.write_addr, 0);
      chk("rst_data", bus.write_data, 0);
      chk("rst_init_done", bus.init_done, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
   endtask
   task automatic release_rst();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask
   task automatic cyc(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit h, output bit r0, output bit r1);
      bit go;
      bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
      bus.rf_hold = h;
      #1;
      go = m_run && !h;
`ifdef RF_ARB_ROUND_ROBIN_EN
      r0 = go && v0 && (!v1 || m_last == 1);
      r1 = go && v1 && (!v0 || m_last == 0);
`else
      r0 = go && v0;
      r1 = go && v1 && !v0;
`endif
      chk("req0_ready", bus.req0_ready, r0);
      chk("req1_ready", bus.req1_ready, r1);
      @(posedge clk);
      if (e_en) mem[e_addr] = e_data;
      if (!m_run) begin
         if (!h) begin
            e_en = 1; e_addr = m_sweep[4:0]; e_data = 0;
            if (m_sweep == 31) m_run = 1;
            m_sweep++;
         end else e_en = 0;
      end else if (r0 || r1) begin
         e_addr = r0 ? a0 : a1;
         e_data = r0 ? d0 : d1;
         e_en = (e_addr != 0);
         m_last = r1 ? 1 : 0;
      end else e_en = 0;
      #1;
      chk("rf_en", bus.rf_en, e_en);
      chk("write_addr", bus.write_addr, e_addr);
      chk("write_data", bus.write_data, e_data);
      chk("init_done", bus.init_done, m_run);
   endtask
   task automatic idle(input int n);
      bit r0, r1;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, r0, r1);
   endtask
   task automatic check_rf();
      for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), (i == 0) ? 32'd0 : rf[i], mem[i]);
   endtask
   initial begin
      bit r0, r1;
      bit p0v, p1v;
      logic [4:0] p0a, p1a;
      logic [31:0] p0d, p1d;
      int g1;
      bus.req0_valid = 1; bus.req0_addr = 0; bus.req0_data = 0;
      bus.req1_valid = 1; bus.req1_addr = 0; bus.req1_data = 0;
      bus.rf_hold = 0;
      reset_now();
      release_rst();
      mem[0] = 0;
      idle(32);
      for (int i = 1; i < 32; i++) chk($sformatf("sweep_x%0d", i), rf[i], 0);
      check_rf();
      cyc(0, 0, 0, 1, 5'd5, 32'hdeadbeef, 0, r0, r1);
      idle(1);
      chk("x5_read", rf[5], 32'hdeadbeef);
      g1 = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 5'd3, 32'h11111111, 1, 5'd4, 32'h22222222, 0, r0, r1);
         g1 += int'(bus.req1_ready);
      end
`ifndef RF_ARB_ROUND_ROBIN_EN
      chk("starve_req1", g1, 0);
`endif
      idle(1);
      for (int i = 0; i < 3; i++) cyc(1, 5'd9, 32'h99990000, 0, 0, 0, 1, r0, r1);
      cyc(1, 5'd9, 32'h99990000, 0, 0, 0, 0, r0, r1);
      cyc(1, 5'd0, 32'hcafef00d, 0, 0, 0, 0, r0, r1);
      idle(1);
      chk("x9_read", rf[9], 32'h99990000);
      check_rf();
      p0v = 0; p1v = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
      for (int i = 0; i < 300; i++) begin
         if (!p0v && $urandom_range(0, 2) != 0) begin p0v = 1; p0a = 5'($urandom); p0d = $urandom; end
         if (!p1v && $urandom_range(0, 2) != 0) begin p1v = 1; p1a = 5'($urandom); p1d = $urandom; end
         cyc(p0v, p0a, p0d, p1v, p1a, p1d, $urandom_range(0, 7) == 0, r0, r1);
         if (r0) p0v = 0;
         if (r1) p1v = 0;
      end
      idle(2);
      check_rf();
      #3;
      reset_now();
      release_rst();
      idle(17);
      chk("sweep_at_17", bus.write_addr, 17);
      #3;
      reset_now();
      release_rst();
      bus.rf_hold = 1;
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 1, r0, r1);
      idle(32);
      check_rf();
      cyc(1, 5'd7, 32'h77777777, 0, 0, 0, 0, r0, r1);
      chk("x7_inflight", bus.rf_en, 1);
      #3;
      reset_now();
      release_rst();
      idle(2);
      chk("x7_cancelled", rf[7], 0);
      idle(31);
      check_rf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencer and arbiter for the single write port of `register_file`. After reset it sweeps zeros into x1..x31, then shares the write port between two writeback requesters over a valid/ready handshake. It drives the register file's `rf_en`, `write_addr` and `write_data` from registered outputs. It sits between the execute/load writeback paths and `register_file`.

## Interface
- `width`, default 32: data width; must match `register_file`.
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a write pending.
- `req0_ready` out 1: requester 0 transfer accepted this cycle.
- `req0_addr` in 5: requester 0 destination register.
- `req0_data` in width: requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1.
- `rf_hold` in 1: stall the write port; no transfer accepted, no sweep step.
- `rf_en` out 1: to `register_file`; write strobe.
- `write_addr` out 5: to `register_file`.
- `write_data` out width: to `register_file`.
- `init_done` out 1: zero sweep complete; arbitration active.

## Operation
- **FSM states:** INIT and RUN. Reset enters INIT.
- **INIT:**
  - 5-bit sweep counter starts at 1.
  - Each cycle with `rf_hold`=0: register `rf_en`=1, `write_addr`=counter, `write_data`=0, then increment the counter.
  - The step that issues address 31 moves to RUN and sets `init_done`=1.
  - `req*_ready`=0 throughout INIT.
- **RUN, grant:**
  - `gnt_i` = requester i wins arbitration among valid requesters.
  - `req_i_ready` = RUN & !`rf_hold` & `gnt_i`. Ready is combinational from valid and state; valid must not depend on ready.
  - At most one ready is high per cycle.
- **Accepted transfer:** on the next posedge the output stage registers `write_addr`/`write_data` from the winner.
  - `rf_en`=1 if addr != 0.
  - `rf_en`=0 if addr == 0; the write is dropped but still counts as a grant.
- **No transfer** (nothing valid, or hold): `rf_en`=0 next cycle; `write_addr`/`write_data` keep their last values.
- **Arbitration:** see Configuration. `last_grant` updates only on an accepted transfer.
- **Same address from both requesters in one cycle:** no merging. The winner is written first; the loser is written on a later grant, so the loser's data is final.
- **Requester contract:** it holds addr/data stable while valid=1 and ready=0.

## Timing
- **Reset values** (asynchronous, immediate): state=INIT, counter=1, `last_grant`=1 (requester 0 favoured first), `rf_en`=0, `write_addr`=0, `write_data`=0, `init_done`=0. Readies are 0 by construction.
- **Sweep:** first posedge after `rst` rises gives `rf_en`=1, `write_addr`=1.
  - With no hold, posedge k (k=1..31) presents address k.
  - `init_done` rises at posedge 31.
  - Posedge 32 presents the first arbitrated write or `rf_en`=0.
- **Hold during INIT:** `rf_en`=0 while held; counter frozen; resumes at the same address.
- **Write latency:** request accepted in cycle n → `rf_en`/addr/data valid in cycle n+1 → register file updated at posedge ending cycle n+1 → data readable in cycle n+2.
- **Throughput:** one write per cycle. Back-to-back grants allowed to the same or alternating requesters.
- **Reset mid-sweep or mid-transfer:** all state returns to reset values at once. An in-flight output write is cancelled (`rf_en`=0). The sweep restarts at address 1.

## Configuration
- **`RF_ARB_ROUND_ROBIN_EN` defined:** round-robin arbitration.
  - When both are valid, grant the requester not equal to `last_grant`.
  - When one is valid, grant it.
- **`RF_ARB_ROUND_ROBIN_EN` undefined:** fixed priority, requester 0 always wins.
  - `last_grant` is still maintained but not used.
  - Requester 1 may starve under a continuous requester 0 stream.

## Test plan
- **Reset and sweep:** hold `rst`=0 for 4 cycles, then release with no requests → `rf_en`=1 with `write_addr`=1..31 on posedges 1..31, `write_data`=0, `init_done`=1 at posedge 31; every `rf_out` entry is 0 afterwards.
- **Single requester:** after init, `req1` writes x5=32'hdeadbeef → `req1_ready`=1 that cycle; next cycle `rf_en`=1, `write_addr`=5; `read_data_a` at `read_addr_a`=5 returns 32'hdeadbeef two cycles after acceptance.
- **Contention:** `req0` (x3=32'h11111111) and `req1` (x4=32'h22222222) both held valid for 4 cycles.
  - Round-robin: grants alternate 0,1,0,1.
  - Fixed priority: grants are 0,0,0,0 and `req1_ready` stays 0.
- **Hold and x0:** assert `rf_hold` for 3 cycles with `req0` valid → `req0_ready`=0 and `rf_en`=0 for those cycles, then acceptance. A `req0` write to x0 → `req0_ready`=1, `rf_en`=0, x0 reads 0.
- **Reset mid-operation:** pull `rst` low at sweep address 17, then release → outputs zero immediately and the sweep restarts at address 1. Repeat during a RUN transfer → the pending write never reaches the register file.
